// File: rtl/spi_slave_responder.sv
// ---------------------------------------------------------------------------
// spi_slave_responder
//   Oversampled SPI slave. The asynchronous sck/ss_L/mosi pins are brought
//   into the clk domain, and one WID-bit word is exchanged per ss_L frame,
//   MSB first. The kernel side uses an arm/finished handshake: arm latches
//   the outgoing word, and finished reports the end of the frame until arm
//   drops.
//
// Parameters
//   WID       bits per word (2..64)
//   POLARITY  idle level of sck (CPOL)
//   PHASE     0: sample on leading edge, 1: sample on trailing edge (CPHA)
//
// Ports
//   clk, rst     system clock (>= 8x sck), synchronous active-high reset
//   sck, ss_L    SPI clock and active-low select (asynchronous)
//   mosi, miso   master-out / slave-out data; miso is 0 outside XFER
//   to_master    word sent to the master, latched when arm rises in IDLE
//   from_master  last word completely received from the master
//   arm          kernel request to accept one transfer
//   finished     frame over (good or errored), held until arm goes low
//   err          last frame ended before WID bits were sampled
// ---------------------------------------------------------------------------
module spi_slave_responder #(
  parameter int WID      = 24,
  parameter bit POLARITY = 1'b0,
  parameter bit PHASE    = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           sck,
  input  logic           ss_L,
  input  logic           mosi,
  output logic           miso,
  input  logic [WID-1:0] to_master,
  output logic [WID-1:0] from_master,
  input  logic           arm,
  output logic           finished,
  output logic           err
);

  localparam int CW = $clog2(WID + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_SS = 2'd1,
    XFER    = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t state, state_nx;

  logic sck_p0, sck_p1, sck_p2;
  logic ss_p0, ss_p1, ss_p2;
  logic mosi_p0, mosi_p1;

  logic [WID-1:0] tx_sr;
  logic [WID-1:0] rx_sr;
  logic [CW-1:0]  bit_cnt;

  logic lead_edge, trail_edge, sample_edge, shift_edge;
  logic ss_fall, ss_rise, cnt_full, first_lead;

  // Synchronizer stages p0/p1; p2 is the edge-detect history stage.
  // Deliberately not reset: after a reset they still track the pins, so a
  // select that was already low never produces a false falling edge.
  always_ff @(posedge clk) begin
    sck_p0  <= sck;
    sck_p1  <= sck_p0;
    sck_p2  <= sck_p1;
    ss_p0   <= ss_L;
    ss_p1   <= ss_p0;
    ss_p2   <= ss_p1;
    mosi_p0 <= mosi;
    mosi_p1 <= mosi_p0;
  end

  // Edge decode on the p1/p2 boundary; mosi_p1 is aligned with sck_p1.
  assign lead_edge   = (sck_p2 == POLARITY) && (sck_p1 != POLARITY);
  assign trail_edge  = (sck_p2 != POLARITY) && (sck_p1 == POLARITY);
  assign sample_edge = PHASE ? trail_edge : lead_edge;
  assign shift_edge  = PHASE ? lead_edge  : trail_edge;
  assign ss_fall     = ss_p2 & ~ss_p1;
  assign ss_rise     = ~ss_p2 & ss_p1;
  assign cnt_full    = (bit_cnt == CW'(WID));
  // With PHASE=1 the MSB is already on miso before the first leading edge,
  // so that edge must not shift it away.
  assign first_lead  = PHASE && (bit_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (arm) state_nx = WAIT_SS;
      end
      WAIT_SS: begin
        if (!arm)        state_nx = IDLE;
        else if (ss_fall) state_nx = XFER;
      end
      XFER: begin
        if (!arm)        state_nx = IDLE;
        else if (ss_rise) state_nx = DONE;
      end
      DONE: begin
        if (!arm) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_sr       <= '0;
      rx_sr       <= '0;
      bit_cnt     <= '0;
      from_master <= '0;
      err         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arm) begin
            tx_sr <= to_master;
            err   <= 1'b0;
          end
        end
        WAIT_SS: begin
          if (arm && ss_fall) begin
            bit_cnt <= '0;
            rx_sr   <= '0;
          end
        end
        XFER: begin
          if (arm) begin
            // End of frame takes priority over a coincident sample edge.
            if (ss_rise) begin
              if (cnt_full) begin
                from_master <= rx_sr;
                err         <= 1'b0;
              end else begin
                err <= 1'b1;
              end
            end else begin
              if (sample_edge && !cnt_full) begin
                rx_sr   <= {rx_sr[WID-2:0], mosi_p1};
                bit_cnt <= bit_cnt + CW'(1);
              end
              if (shift_edge && !cnt_full && !first_lead) begin
                tx_sr <= {tx_sr[WID-2:0], 1'b0};
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign miso     = (state == XFER && !cnt_full) ? tx_sr[WID-1] : 1'b0;
  assign finished = (state == DONE);

endmodule

// File: tb/tb_spi_slave_responder.sv
module tb_spi_slave_responder;

  localparam int W       = 24;
  localparam int EV_NONE = 0;
  localparam int EV_RST  = 1;
  localparam int EV_ARM  = 2;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] sck, ss_L, mosi, miso, arm, finished, err;
  logic [W-1:0] to_master   [4];
  logic [W-1:0] from_master [4];

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state: what from_master/err should hold per instance.
  logic [W-1:0] mdl_from [4];
  bit           mdl_err  [4];

  always #5 clk = ~clk;

  // Instance index m = POLARITY*2 + PHASE.
  spi_slave_responder #(.WID(W), .POLARITY(1'b0), .PHASE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .sck(sck[0]), .ss_L(ss_L[0]), .mosi(mosi[0]), .miso(miso[0]),
    .to_master(to_master[0]), .from_master(from_master[0]), .arm(arm[0]),
    .finished(finished[0]), .err(err[0]));
  spi_slave_responder #(.WID(W), .POLARITY(1'b0), .PHASE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .sck(sck[1]), .ss_L(ss_L[1]), .mosi(mosi[1]), .miso(miso[1]),
    .to_master(to_master[1]), .from_master(from_master[1]), .arm(arm[1]),
    .finished(finished[1]), .err(err[1]));
  spi_slave_responder #(.WID(W), .POLARITY(1'b1), .PHASE(1'b0)) dut2 (
    .clk(clk), .rst(rst), .sck(sck[2]), .ss_L(ss_L[2]), .mosi(mosi[2]), .miso(miso[2]),
    .to_master(to_master[2]), .from_master(from_master[2]), .arm(arm[2]),
    .finished(finished[2]), .err(err[2]));
  spi_slave_responder #(.WID(W), .POLARITY(1'b1), .PHASE(1'b1)) dut3 (
    .clk(clk), .rst(rst), .sck(sck[3]), .ss_L(ss_L[3]), .mosi(mosi[3]), .miso(miso[3]),
    .to_master(to_master[3]), .from_master(from_master[3]), .arm(arm[3]),
    .finished(finished[3]), .err(err[3]));

  // What the master should read: the armed word MSB first for the bits the
  // slave was live for, zeros afterwards (and beyond WID).
  function automatic logic [63:0] model_rx(input logic [W-1:0] tm, input int nbits, input int live);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < nbits; i++)
      r = {r[62:0], (i < live && i < W) ? tm[W-1-i] : 1'b0};
    return r;
  endfunction

  // Word the slave should keep from a complete frame: the first W bits sent.
  function automatic logic [W-1:0] model_word(input logic [63:0] tx, input int nbits);
    return W'(tx >> (nbits - W));
  endfunction

  task automatic arm_word(input int m, input logic [W-1:0] tm);
    to_master[m] = tm;
    arm[m] = 1'b1;
    mdl_err[m] = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_fin(input int m, output bit got);
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (finished[m] === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  // SPI master at clk/10. Drives pins on falling clk edges.
  task automatic spi_frame(input int m, input logic [63:0] tx, input int nbits,
                           input int ev_at, input int ev_kind, input bit ss_pre_low,
                           output logic [63:0] rx);
    bit pol, pha;
    pol = (m / 2) == 1;
    pha = (m % 2) == 1;
    rx = '0;
    @(negedge clk);
    if (!ss_pre_low) ss_L[m] = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i == ev_at && ev_kind == EV_RST) begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
      end
      if (i == ev_at && ev_kind == EV_ARM) arm[m] = 1'b0;
      if (i == 5) to_master[m] = W'($urandom);
      if (!pha) begin
        mosi[m] = tx[nbits-1-i];
        repeat (5) @(negedge clk);
        sck[m] = ~pol;
        rx = {rx[62:0], miso[m]};
        repeat (5) @(negedge clk);
        sck[m] = pol;
      end else begin
        repeat (5) @(negedge clk);
        sck[m] = ~pol;
        mosi[m] = tx[nbits-1-i];
        repeat (5) @(negedge clk);
        sck[m] = pol;
        rx = {rx[62:0], miso[m]};
      end
    end
    repeat (5) @(negedge clk);
    ss_L[m] = 1'b1;
    mosi[m] = 1'b0;
  endtask

  task automatic disarm(input int m);
    arm[m] = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (finished[m] !== 1'b0) begin
      n_fail++;
      $display("FAIL finished_drop m=%0d got %b want 0", m, finished[m]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int m = 0; m < 4; m++) begin
      n_cmp++;
      if ({miso[m], finished[m], err[m]} !== 3'b000 || from_master[m] !== '0) begin
        n_fail++;
        $display("FAIL reset_state m=%0d got miso/fin/err=%b%b%b from=%h want 000 / 0",
                 m, miso[m], finished[m], err[m], from_master[m]);
      end
      mdl_from[m] = '0;
      mdl_err[m]  = 1'b0;
    end
  endtask

  task automatic test_basic();
    logic [63:0] rx;
    bit got;
    arm_word(0, 24'hA5F00F);
    spi_frame(0, 64'h123456, 24, -1, EV_NONE, 1'b0, rx);
    wait_fin(0, got);
    n_cmp++;
    if (!got) begin n_fail++; $display("FAIL basic_finished got 0 want 1"); end
    n_cmp++;
    if (rx[23:0] !== 24'hA5F00F) begin n_fail++; $display("FAIL basic_miso got %h want a5f00f", rx[23:0]); end
    n_cmp++;
    if (from_master[0] !== 24'h123456) begin n_fail++; $display("FAIL basic_from got %h want 123456", from_master[0]); end
    n_cmp++;
    if (err[0] !== 1'b0) begin n_fail++; $display("FAIL basic_err got %b want 0", err[0]); end
    mdl_from[0] = 24'h123456;
    disarm(0);
  endtask

  task automatic test_early_end();
    logic [63:0] rx;
    bit got;
    arm_word(0, 24'hA5F00F);
    spi_frame(0, 64'h2AB, 10, -1, EV_NONE, 1'b0, rx);
    wait_fin(0, got);
    n_cmp++;
    if (!got) begin n_fail++; $display("FAIL early_finished got 0 want 1"); end
    n_cmp++;
    if (err[0] !== 1'b1) begin n_fail++; $display("FAIL early_err got %b want 1", err[0]); end
    n_cmp++;
    if (from_master[0] !== 24'h123456) begin n_fail++; $display("FAIL early_from got %h want 123456", from_master[0]); end
    n_cmp++;
    if (rx !== model_rx(24'hA5F00F, 10, 10)) begin n_fail++; $display("FAIL early_miso got %h want %h", rx, model_rx(24'hA5F00F, 10, 10)); end
    mdl_err[0] = 1'b1;
    disarm(0);
  endtask

  task automatic test_modes();
    logic [63:0] rx;
    bit got;
    for (int m = 0; m < 4; m++) begin
      arm_word(m, 24'hC0FFEE);
      spi_frame(m, 64'hC0FFEE, 24, -1, EV_NONE, 1'b0, rx);
      wait_fin(m, got);
      n_cmp++;
      if (!got || err[m] !== 1'b0) begin
        n_fail++;
        $display("FAIL mode_done m=%0d got fin=%b err=%b want 1 0", m, got, err[m]);
      end
      n_cmp++;
      if (rx[23:0] !== 24'hC0FFEE) begin n_fail++; $display("FAIL mode_miso m=%0d got %h want c0ffee", m, rx[23:0]); end
      n_cmp++;
      if (from_master[m] !== 24'hC0FFEE) begin n_fail++; $display("FAIL mode_from m=%0d got %h want c0ffee", m, from_master[m]); end
      mdl_from[m] = 24'hC0FFEE;
      disarm(m);
    end
  endtask

  task automatic test_preselected();
    logic [63:0] rx, tx;
    logic [W-1:0] tm;
    bit got;
    ss_L[1] = 1'b0;
    repeat (8) @(negedge clk);
    tm = W'($urandom);
    tx = 64'($urandom);
    arm_word(1, tm);
    spi_frame(1, tx, 24, -1, EV_NONE, 1'b1, rx);
    repeat (20) @(negedge clk);
    n_cmp++;
    if (finished[1] !== 1'b0) begin n_fail++; $display("FAIL presel_finished got %b want 0", finished[1]); end
    n_cmp++;
    if (from_master[1] !== mdl_from[1] || rx !== 64'd0) begin
      n_fail++;
      $display("FAIL presel_ignored got from=%h rx=%h want from=%h rx=0", from_master[1], rx, mdl_from[1]);
    end
    spi_frame(1, tx, 24, -1, EV_NONE, 1'b0, rx);
    wait_fin(1, got);
    n_cmp++;
    if (!got || from_master[1] !== model_word(tx, 24) || rx[23:0] !== tm) begin
      n_fail++;
      $display("FAIL presel_next got fin=%b from=%h rx=%h want 1 %h %h", got, from_master[1], rx[23:0], model_word(tx, 24), tm);
    end
    mdl_from[1] = model_word(tx, 24);
    disarm(1);
  endtask

  task automatic test_overlong();
    logic [63:0] rx, tx;
    logic [W-1:0] tm;
    bit got;
    tm = W'($urandom);
    tx = {$urandom, $urandom};
    arm_word(2, tm);
    spi_frame(2, tx, 30, -1, EV_NONE, 1'b0, rx);
    wait_fin(2, got);
    n_cmp++;
    if (!got || err[2] !== 1'b0) begin n_fail++; $display("FAIL long_done got fin=%b err=%b want 1 0", got, err[2]); end
    n_cmp++;
    if (from_master[2] !== model_word(tx, 30)) begin n_fail++; $display("FAIL long_from got %h want %h", from_master[2], model_word(tx, 30)); end
    n_cmp++;
    if (rx !== model_rx(tm, 30, 30)) begin n_fail++; $display("FAIL long_miso got %h want %h", rx, model_rx(tm, 30, 30)); end
    mdl_from[2] = model_word(tx, 30);
    disarm(2);
  endtask

  task automatic test_reset_mid();
    logic [63:0] rx, tx;
    logic [W-1:0] tm;
    bit got;
    tm = W'($urandom);
    tx = 64'($urandom);
    arm_word(0, tm);
    spi_frame(0, tx, 24, 12, EV_RST, 1'b0, rx);
    for (int m = 0; m < 4; m++) begin
      mdl_from[m] = '0;
      mdl_err[m]  = 1'b0;
    end
    repeat (20) @(negedge clk);
    n_cmp++;
    if (finished[0] !== 1'b0 || err[0] !== 1'b0 || from_master[0] !== '0) begin
      n_fail++;
      $display("FAIL rstmid_state got fin=%b err=%b from=%h want 0 0 0", finished[0], err[0], from_master[0]);
    end
    n_cmp++;
    if (rx !== model_rx(tm, 24, 12)) begin n_fail++; $display("FAIL rstmid_miso got %h want %h", rx, model_rx(tm, 24, 12)); end
    // Arm stayed high through reset, so the slave re-latched whatever word
    // was presented when it came back to IDLE.
    tm = to_master[0];
    tx = 64'($urandom);
    spi_frame(0, tx, 24, -1, EV_NONE, 1'b0, rx);
    wait_fin(0, got);
    n_cmp++;
    if (!got || from_master[0] !== model_word(tx, 24) || rx[23:0] !== tm) begin
      n_fail++;
      $display("FAIL rstmid_next got fin=%b from=%h rx=%h want 1 %h %h", got, from_master[0], rx[23:0], model_word(tx, 24), tm);
    end
    mdl_from[0] = model_word(tx, 24);
    disarm(0);
  endtask

  task automatic test_arm_abort();
    logic [63:0] rx, tx;
    logic [W-1:0] tm;
    tm = W'($urandom);
    tx = 64'($urandom);
    arm_word(0, tm);
    spi_frame(0, tx, 24, 8, EV_ARM, 1'b0, rx);
    repeat (20) @(negedge clk);
    n_cmp++;
    if (finished[0] !== 1'b0 || from_master[0] !== mdl_from[0] || err[0] !== mdl_err[0]) begin
      n_fail++;
      $display("FAIL abort_state got fin=%b from=%h err=%b want 0 %h %b", finished[0], from_master[0], err[0], mdl_from[0], mdl_err[0]);
    end
    n_cmp++;
    if (rx !== model_rx(tm, 24, 8)) begin n_fail++; $display("FAIL abort_miso got %h want %h", rx, model_rx(tm, 24, 8)); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] rx, tx;
    logic [W-1:0] tm;
    int m, nbits, kind;
    bit got;
    for (int it = 0; it < 16; it++) begin
      m    = $urandom_range(0, 3);
      kind = $urandom_range(0, 3);
      nbits = (kind == 1) ? $urandom_range(2, W-1) : (kind == 2) ? $urandom_range(W+1, 40) : W;
      tm = W'($urandom);
      tx = {$urandom, $urandom};
      arm_word(m, tm);
      spi_frame(m, tx, nbits, -1, EV_NONE, 1'b0, rx);
      if (nbits >= W) begin
        mdl_from[m] = model_word(tx, nbits);
        mdl_err[m]  = 1'b0;
      end else begin
        mdl_err[m]  = 1'b1;
      end
      wait_fin(m, got);
      n_cmp++;
      if (!got) begin n_fail++; $display("FAIL b2b_finished it=%0d m=%0d got 0 want 1", it, m); end
      n_cmp++;
      if (from_master[m] !== mdl_from[m] || err[m] !== mdl_err[m]) begin
        n_fail++;
        $display("FAIL b2b_result it=%0d m=%0d n=%0d got from=%h err=%b want %h %b",
                 it, m, nbits, from_master[m], err[m], mdl_from[m], mdl_err[m]);
      end
      n_cmp++;
      if (rx !== model_rx(tm, nbits, nbits)) begin
        n_fail++;
        $display("FAIL b2b_miso it=%0d m=%0d n=%0d got %h want %h", it, m, nbits, rx, model_rx(tm, nbits, nbits));
      end
      disarm(m);
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst  = 1'b1;
    sck  = 4'b1100;
    ss_L = 4'b1111;
    mosi = 4'b0000;
    arm  = 4'b0000;
    for (int m = 0; m < 4; m++) to_master[m] = '0;
    test_reset();
    test_basic();
    test_early_end();
    test_modes();
    test_preselected();
    test_overlong();
    test_reset_mid();
    test_arm_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
